// File: rtl/osc_decimator_pkg.sv
// Shared constants, types and helpers for the oscilloscope decimator.
package osc_decimator_pkg;

  localparam int unsigned MODE_MAX  = 4;
  localparam int unsigned DIV_ITER  = 25;
  localparam int unsigned OUT_SHIFT = 18;
  localparam int unsigned CNT_W     = 14;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [2:0]       mode_t;

  localparam cnt_t WIN_LEN [0:MODE_MAX] = '{14'd1, 14'd10, 14'd100, 14'd1000, 14'd10000};

  typedef enum logic {
    DIV_IDLE = 1'b0,
    DIV_BUSY = 1'b1
  } div_state_t;

  function automatic mode_t clamp_mode(input logic [3:0] m);
    return (m > 4'(MODE_MAX)) ? mode_t'(MODE_MAX) : m[2:0];
  endfunction

  // 12-bit signed result placed at [29:18], sign-extended above.
  function automatic logic [31:0] align_out(input logic [11:0] v);
    return 32'($signed(v)) << OUT_SHIFT;
  endfunction

endpackage

// File: rtl/osc_decimator_if.sv
// Sample input / decimated output bundle of osc_decimator.
interface osc_decimator_if;
  logic [11:0] adc_in;
  logic        adc_valid;
  logic [3:0]  Mode;
  logic        ovr_clr;
  logic [31:0] dec_out;
  logic        dec_valid;
  logic        overrun;

  modport master (
    output adc_in, adc_valid, Mode, ovr_clr,
    input  dec_out, dec_valid, overrun
  );

  modport slave (
    input  adc_in, adc_valid, Mode, ovr_clr,
    output dec_out, dec_valid, overrun
  );
endinterface

// File: rtl/osc_decimator_divider.sv
// Sequential restoring divider: |dividend| / divisor over 25 iterations, signed, saturated result.
module dec_divider
  import osc_decimator_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [13:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [11:0] quotient
);

  localparam int unsigned MAG_W = DIV_ITER;

  div_state_t       state, state_nxt;
  logic [4:0]       iter;
  logic [MAG_W-1:0] quo;
  logic [MAG_W-1:0] mag;
  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] dsr;
  logic             neg;
  logic             last;
  logic [CNT_W:0]   rem_sh, rem_sub;
  logic             rem_ge;

  // |sum| of a full window never exceeds 10000*2048, which fits in MAG_W bits.
  assign mag     = MAG_W'(dividend[31] ? -dividend : dividend);
  assign last    = (iter == 5'(DIV_ITER));
  assign rem_sh  = {rem, quo[MAG_W-1]};
  assign rem_ge  = (rem_sh >= {1'b0, dsr});
  assign rem_sub = rem_sh - {1'b0, dsr};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= DIV_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      DIV_IDLE: if (start) state_nxt = DIV_BUSY;
      DIV_BUSY: if (last)  state_nxt = DIV_IDLE;
      default:             state_nxt = DIV_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state == DIV_BUSY);
    done     = busy && last;
    quotient = '0;
    if (neg) quotient = (quo > MAG_W'(2048)) ? 12'h800 : 12'(-quo);
    else     quotient = (quo > MAG_W'(2047)) ? 12'h7FF : quo[11:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iter <= '0;
      quo  <= '0;
      rem  <= '0;
      dsr  <= '0;
      neg  <= 1'b0;
    end else if (state == DIV_IDLE) begin
      if (start) begin
        iter <= '0;
        quo  <= mag;
        rem  <= '0;
        dsr  <= divisor;
        neg  <= dividend[31];
      end
    end else if (!last) begin
      // Dividend bits shift out of quo's top while quotient bits enter at the bottom.
      rem  <= rem_ge ? rem_sub[CNT_W-1:0] : rem_sh[CNT_W-1:0];
      quo  <= {quo[MAG_W-2:0], rem_ge};
      iter <= iter + 5'd1;
    end
  end

endmodule

// File: rtl/osc_decimator.sv
// ADC sample decimator: windowed accumulation of 10**Mode samples, averaged by dec_divider.
module osc_decimator
  import osc_decimator_pkg::*;
(
  input  logic           Fg_CLK,
  input  logic           RESET,
  osc_decimator_if.slave bus
);

  logic signed [11:0] sample;
  logic signed [31:0] acc, acc_sum;
  cnt_t               cnt, win_len;
  mode_t              mode_lat, mode_cur;
  logic               dump, bypass, div_start, drop;
  logic               div_busy, div_done;
  logic [11:0]        div_q;

  assign sample  = {~bus.adc_in[11], bus.adc_in[10:0]};
  assign acc_sum = acc + 32'(sample);

  // The first sample of a window sees the live Mode; later samples use the latched one.
  assign mode_cur  = (cnt == '0) ? clamp_mode(bus.Mode) : mode_lat;
  assign win_len   = WIN_LEN[mode_cur];
  assign dump      = bus.adc_valid && (cnt == win_len - cnt_t'(1));
  assign bypass    = dump && (mode_cur == '0);
  assign div_start = dump && (mode_cur != '0) && !div_busy;
  // A bypass sample colliding with a divider result is dropped as well.
  assign drop      = (dump && (mode_cur != '0) && div_busy) || (bypass && div_done);

  dec_divider u_div (
    .clk      (Fg_CLK),
    .rst      (RESET),
    .start    (div_start),
    .dividend (acc_sum),
    .divisor  (win_len),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_q)
  );

  always_ff @(posedge Fg_CLK or posedge RESET) begin
    if (RESET) begin
      acc      <= '0;
      cnt      <= '0;
      mode_lat <= '0;
    end else if (bus.adc_valid) begin
      if (cnt == '0) mode_lat <= clamp_mode(bus.Mode);
      if (dump) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= acc_sum;
        cnt <= cnt + cnt_t'(1);
      end
    end
  end

  always_ff @(posedge Fg_CLK or posedge RESET) begin
    if (RESET) begin
      bus.dec_out   <= '0;
      bus.dec_valid <= 1'b0;
      bus.overrun   <= 1'b0;
    end else begin
      bus.dec_valid <= 1'b0;
      if (div_done) begin
        bus.dec_valid <= 1'b1;
        bus.dec_out   <= align_out(div_q);
      end else if (bypass) begin
        bus.dec_valid <= 1'b1;
        bus.dec_out   <= align_out(sample);
      end
      bus.overrun <= drop | (bus.overrun & ~bus.ovr_clr);
    end
  end

endmodule

// File: doc/osc_decimator.md
OSC_DECIMATOR -- requirements
Module: osc_decimator

Interface
REQ-001 SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 Fg_CLK  input  1  clock; all state changes on its rising edge.
REQ-003 RESET  input  1  asynchronous active-high reset.
REQ-004 adc_in  input  12  sample in offset binary: unsigned; 12'h800 = zero.
REQ-005 adc_valid  input  1  one-cycle strobe; adc_in is sampled when this is high.
REQ-006 Mode  input  4  decimation exponent; window length N = 10**Mode; values above 4 clamp to 4.
REQ-007 ovr_clr  input  1  clears the sticky overrun flag.
REQ-008 dec_out  output  32  signed window average; 12-bit result in bits [29:18], sign-extended above, zero below.
REQ-009 dec_valid  output  1  one-cycle strobe marking a new dec_out.
REQ-010 overrun  output  1  sticky flag: a window was dropped because the divider was busy.

Function
REQ-011 Each accepted sample SHALL convert to signed as {~adc_in[11], adc_in[10:0]}, range -2048..2047.
REQ-012 The accumulator SHALL be 32-bit signed; the worst case (10000 x 2048) SHALL NOT overflow it.
REQ-013 Mode SHALL be latched when the first sample of a window is accepted; a Mode change mid-window applies from the next window.
REQ-014 Sample counter SHALL count accepted samples 0..N-1; on the Nth sample (dump) the completed sum goes to the divider, and the accumulator and counter restart from zero on the same edge.
REQ-015 With Mode=0 (N=1) the divider SHALL be bypassed: dec_out = sample<<18, and dec_valid is asserted on the edge after the adc_valid edge (latency 1).
REQ-016 With Mode 1..4 the average SHALL be sum/N, truncated toward zero (signed division semantics).
REQ-017 Quotient magnitude range is 0..2048; the result SHALL saturate to -2048..2047 before the <<18 alignment.
REQ-018 The divider SHALL be sequential with two states, IDLE and BUSY.
REQ-019 IDLE->BUSY on dump: load |sum| and N.
REQ-020 BUSY SHALL run exactly 25 restoring iterations, then apply the sign, return to IDLE and register the result.
REQ-021 For Mode>=1, dec_valid SHALL pulse exactly 26 cycles after the edge that accepted the Nth sample.
REQ-022 Accumulation of the next window SHALL continue while the divider is BUSY.
REQ-023 Dump while BUSY: that window's sum SHALL be discarded, the in-progress division continues unaffected, and overrun is set.
REQ-024 overrun SHALL stay set until ovr_clr; if set and clear occur on the same edge, set wins.
REQ-025 dec_out SHALL hold its last value between dec_valid pulses.
REQ-026 adc_valid low SHALL freeze the accumulator and counter; there is no timeout.

Reset
REQ-027 On RESET high, immediately and asynchronously: dec_out=0, dec_valid=0, overrun=0, accumulator=0, counter=0, divider IDLE, latched Mode=0.
REQ-028 RESET during BUSY SHALL abort the division; no dec_valid is produced for the aborted window after release.
REQ-029 The first window after release SHALL begin with the first accepted sample.

Structure
REQ-030 A shared package SHALL hold: MODE_MAX=4, the window-length table {1,10,100,1000,10000}, DIV_ITER=25, OUT_SHIFT=18, and the divider state encoding.
REQ-031 The divider SHALL be a separate sub-module, dec_divider (start/busy/done handshake, 32-bit dividend, 14-bit divisor); osc_decimator holds conversion, accumulation, counting and output registers.

Verification
REQ-032 Mode=0, adc_in=12'hFFF with a single adc_valid -> next cycle dec_valid=1 and dec_out=32'h1FFC0000.
REQ-033 Mode=1, ten samples of 12'h864 spaced 3 cycles apart -> dec_out=32'h01900000, with dec_valid exactly 26 cycles after the 10th strobe.
REQ-034 Mode=1, one sample 12'h7F1 (-15) plus nine of 12'h800 -> average -1.5 truncates to -1 -> dec_out=32'hFFFC0000.
REQ-035 Mode=1, adc_valid high continuously for 20 cycles -> first window reported; second dump lands while BUSY, so overrun=1 and only one dec_valid occurs; overrun clears on an ovr_clr pulse.
REQ-036 Mode=2 window in progress, RESET pulsed 10 cycles after the dump -> all outputs 0 immediately; no dec_valid for 40 cycles after release with adc_valid held low.
REQ-037 Mode changed 1->3 after the 5th sample -> current window still closes at 10 samples; the next window closes at 1000 samples.
